audio_upsampler: RTL and testbench

AUDIO_UPSAMPLER -- requirements
Module: audio_upsampler

---
 rtl/audio_pkg.sv | 25 ++
 rtl/audio_upsampler_fifo.sv | 88 ++++++++
 rtl/audio_upsampler.sv | 149 ++++++++++++++
 tb/tb_audio_upsampler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio upsampler slice.
//   sample_t      signed 16-bit two's-complement PCM sample
//   dac_word_t    unsigned 16-bit offset-binary word for the delta-sigma DAC
//   DAC_MIDSCALE  DAC word representing a zero-level sample
//   VOL_W         width of the volume code
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [SAMPLE_W-1:0] dac_word_t;

    localparam dac_word_t DAC_MIDSCALE = 16'h8000;

    // Two's complement to excess-2^15: flipping the sign bit shifts the
    // range from [-32768, 32767] to [0, 65535].
    function automatic dac_word_t to_offset_binary(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_upsampler_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO of signed PCM samples between the producer and the
// sample-rate output stage.
// Parameters:
//   DEPTH    number of entries (power of two, minimum 2)
// Ports:
//   Clk      clock, all state updates on the rising edge
//   Reset    synchronous active-high reset, empties the FIFO
//   push     write wr_data this cycle (ignored while full)
//   wr_data  sample to write
//   pop      remove the oldest entry this cycle (ignored while empty)
//   rd_data  oldest entry (valid whenever empty is 0)
//   full     occupancy equals DEPTH
//   empty    occupancy equals 0
// ---------------------------------------------------------------------------
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    Clk,
    input  logic    Reset,
    input  logic    push,
    input  sample_t wr_data,
    input  logic    pop,
    output sample_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    sample_t       mem_q [DEPTH];
    sample_t       mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two; the extra
    // count bit distinguishes full from empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/audio_upsampler.sv
// ---------------------------------------------------------------------------
// audio_upsampler
// Buffers PCM samples, releases one per output sample period, applies a
// 4-bit volume and produces the offset-binary word for a delta-sigma DAC.
// Build option:
//   AUDIO_UPSAMPLER_INTERP_EN  defined   -> linear ramp between samples
//                              undefined -> zero-order hold
// Parameters:
//   DEPTH     sample FIFO depth (power of two, minimum 2)
//   DIV_LOG2  log2 of Clk cycles per output sample period
// Ports:
//   Clk       clock
//   Reset     synchronous active-high reset
//   s_data    signed PCM sample input
//   s_valid   s_data valid this cycle
//   s_ready   a sample is accepted this cycle (FIFO not full)
//   vol       volume code, gain = (vol+1)/16
//   dac_data  registered offset-binary DAC word
//   tick      one-cycle pulse at each sample-period boundary
//   underrun  one-cycle pulse on a tick that finds the FIFO empty
// ---------------------------------------------------------------------------
module audio_upsampler
    import audio_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DIV_LOG2 = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [VOL_W-1:0] vol,
    output logic [15:0]      dac_data,
    output logic             tick,
    output logic             underrun
);

    logic [DIV_LOG2-1:0] cnt_q, cnt_d;
    sample_t             cur_q, cur_d;
    dac_word_t           dac_q, dac_d;

    logic                fifo_full;
    logic                fifo_empty;
    sample_t             fifo_rd_data;
    logic                push;
    logic                pop;

    sample_t             level;
    logic signed [20:0]  gain;
    logic signed [20:0]  prod;
    sample_t             scaled;

`ifdef AUDIO_UPSAMPLER_INTERP_EN
    localparam int ACC_W = 17 + DIV_LOG2;

    sample_t                  nxt_q, nxt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [16:0]       ramp_step;
`endif

    assign tick     = &cnt_q;
    assign s_ready  = !fifo_full;
    assign push     = s_valid && s_ready;
    assign pop      = tick && !fifo_empty;
    assign underrun = tick && fifo_empty;
    assign dac_data = dac_q;

    sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .Clk    (Clk),
        .Reset  (Reset),
        .push   (push),
        .wr_data(s_data),
        .pop    (pop),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef AUDIO_UPSAMPLER_INTERP_EN
    // Over one period acc sums (nxt-cur) once per non-tick cycle, so the
    // level walks from cur towards nxt and lands on nxt at the next tick,
    // when cur takes over nxt's value and acc restarts.
    always_comb begin
        cnt_d     = cnt_q + DIV_LOG2'(1);
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        acc_d     = acc_q;
        ramp_step = $signed({nxt_q[15], nxt_q}) - $signed({cur_q[15], cur_q});
        if (tick) begin
            cur_d = nxt_q;
            acc_d = '0;
            if (pop) begin
                nxt_d = fifo_rd_data;
            end
        end else begin
            acc_d = acc_q + $signed({{DIV_LOG2{ramp_step[16]}}, ramp_step});
        end
        level = 16'($signed({{(DIV_LOG2+1){cur_q[15]}}, cur_q}) + (acc_q >>> DIV_LOG2));
    end
`else
    // Zero-order hold: the popped sample is held for the whole period and
    // the previous one is kept when the FIFO runs dry.
    always_comb begin
        cnt_d = cnt_q + DIV_LOG2'(1);
        cur_d = cur_q;
        if (pop) begin
            cur_d = fifo_rd_data;
        end
        level = cur_q;
    end
`endif

    // Gain (vol+1)/16 never exceeds unity, so the 21-bit product shifted
    // down by 4 always fits back into 16 bits without clipping.
    always_comb begin
        gain   = {16'd0, ({1'b0, vol} + 5'd1)};
        prod   = {{5{level[15]}}, level} * gain;
        scaled = 16'(prod >>> 4);
        dac_d  = to_offset_binary(scaled);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
            cur_q <= '0;
            dac_q <= DAC_MIDSCALE;
        end else begin
            cnt_q <= cnt_d;
            cur_q <= cur_d;
            dac_q <= dac_d;
        end
    end

`ifdef AUDIO_UPSAMPLER_INTERP_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            nxt_q <= '0;
            acc_q <= '0;
        end else begin
            nxt_q <= nxt_d;
            acc_q <= acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_audio_upsampler.sv
// ---------------------------------------------------------------------------
// tb_audio_upsampler
// Scoreboard bench: a reference model of the upsampler computes the expected
// per-cycle outputs and queues them; a monitor compares them against the
// DUT. Directed sequences pin down the reset, volume, back-pressure and
// reset-during-playback behaviour with fixed expected values.
// ---------------------------------------------------------------------------
module tb_audio_upsampler;

    localparam int DEPTH    = 8;
    localparam int DIV_LOG2 = 4;
    localparam int PERIOD   = 1 << DIV_LOG2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  vol;
    logic [15:0] dac_data;
    logic        tick;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] dac;
        logic        rdy;
        logic        tk;
        logic        ur;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: a queue of buffered samples, position in the
    // period, and the samples bounding the current period.
    int          m_q[$];
    int          m_cnt;
    int          m_cur;
    int          m_nxt;
    logic [15:0] m_dac;
    bit          armed = 1'b0;
    bit          m_tick;
    int          m_size;
    bit          m_pop;
    bit          m_push;
    int          m_popped;

    always #5 Clk = ~Clk;

    audio_upsampler #(
        .DEPTH   (DEPTH),
        .DIV_LOG2(DIV_LOG2)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .vol     (vol),
        .dac_data(dac_data),
        .tick    (tick),
        .underrun(underrun)
    );

    // Level c cycles into a period.
    function automatic int levelAt(input int cur, input int nxt, input int c);
`ifdef AUDIO_UPSAMPLER_INTERP_EN
        return cur + ((c * (nxt - cur)) >>> DIV_LOG2);
`else
        return cur;
`endif
    endfunction

    function automatic logic [15:0] dacWord(input int level, input int v);
        int p;
        p = (level * (v + 1)) >>> 4;
        return 16'(p) ^ 16'h8000;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic waitNextTick();
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 4 * PERIOD) begin
            step();
            n++;
        end
        checkOutput("tick_timeout", {15'd0, tick}, 16'd1);
    endtask

    task automatic pushOne(input logic [15:0] data);
        s_data  = data;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    // Push one sample, let two periods elapse so both builds settle on it,
    // then check the DAC word.
    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] v,
                                 input logic [15:0] expected, input string name);
        vol = v;
        pushOne(data);
        waitNextTick();
        waitNextTick();
        step();
        step();
        checkOutput(name, dac_data, expected);
    endtask

    // Model: at each falling edge, record this cycle's expected outputs and
    // advance to the next cycle using this cycle's inputs.
    initial begin
        forever begin
            @(negedge Clk);
            if (armed) begin
                exp_q.push_back('{dac: m_dac,
                                  rdy: (m_q.size() < DEPTH),
                                  tk:  (m_cnt == PERIOD - 1),
                                  ur:  (m_cnt == PERIOD - 1) && (m_q.size() == 0)});
            end
            if (Reset === 1'b1) begin
                m_q.delete();
                m_cnt = 0;
                m_cur = 0;
                m_nxt = 0;
                m_dac = 16'h8000;
                armed = 1'b1;
            end else if (armed) begin
                m_tick   = (m_cnt == PERIOD - 1);
                m_size   = m_q.size();
                m_pop    = m_tick && (m_size > 0);
                m_push   = (s_valid === 1'b1) && (m_size < DEPTH);
                m_popped = 0;
                m_dac    = dacWord(levelAt(m_cur, m_nxt, m_cnt), int'(vol));
                if (m_pop) m_popped = m_q.pop_front();
                if (m_push) m_q.push_back(int'($signed(s_data)));
                if (m_tick) begin
`ifdef AUDIO_UPSAMPLER_INTERP_EN
                    m_cur = m_nxt;
                    if (m_pop) m_nxt = m_popped;
`else
                    if (m_pop) m_cur = m_popped;
`endif
                end
                m_cnt = (m_cnt + 1) % PERIOD;
            end
        end
    end

    // Monitor: compare the DUT against each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_dac_data", dac_data, e.dac);
                checkOutput("sb_s_ready", {15'd0, s_ready}, {15'd0, e.rdy});
                checkOutput("sb_tick", {15'd0, tick}, {15'd0, e.tk});
                checkOutput("sb_underrun", {15'd0, underrun}, {15'd0, e.ur});
            end
        end
    end

    initial begin
        int urCount;
        int midErrors;
        int prob;

        Reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        vol     = 4'd15;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_dac", dac_data, 16'h8000);
        checkOutput("reset_ready", {15'd0, s_ready}, 16'd1);
        checkOutput("reset_tick", {15'd0, tick}, 16'd0);
        Reset = 1'b0;

        // Three idle periods: one underrun per tick, DAC stays at midscale.
        urCount   = 0;
        midErrors = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (underrun === 1'b1) urCount++;
            if (dac_data !== 16'h8000) midErrors++;
            step();
        end
        checkOutput("idle_underruns", 16'(urCount), 16'd3);
        checkOutput("idle_midscale", 16'(midErrors), 16'd0);

        applyStimulus(16'h7FFF, 4'd0, 16'h87FF, "max_pos_vol0");
        applyStimulus(16'h8000, 4'd7, 16'h4000, "max_neg_vol7");
        applyStimulus(16'h1000, 4'd15, 16'h9000, "unity_1000");
        repeat (5) step();
        checkOutput("unity_1000_held", dac_data, 16'h9000);

        // Back-pressure: fill from the start of a period, hold s_valid
        // across the tick.
        waitNextTick();
        step();
        for (int i = 0; i < 9; i++) begin
            s_data  = 16'($urandom);
            s_valid = 1'b1;
            if (i == 8) checkOutput("full_ready_low", {15'd0, s_ready}, 16'd0);
            step();
        end
        waitNextTick();
        checkOutput("full_at_tick", {15'd0, s_ready}, 16'd0);
        step();
        checkOutput("ready_after_pop", {15'd0, s_ready}, 16'd1);
        step();
        checkOutput("refull_after_push", {15'd0, s_ready}, 16'd0);
        s_valid = 1'b0;

        // Randomized traffic with varying push density and volume.
        for (int seg = 0; seg < 4; seg++) begin
            prob = (seg == 0) ? 5 : (seg == 1) ? 20 : (seg == 2) ? 60 : 10;
            for (int i = 0; i < 150; i++) begin
                s_valid = ($urandom_range(0, 99) < prob);
                s_data  = 16'($urandom);
                if ((i % 16) == 0) vol = 4'($urandom_range(0, 15));
                Reset = (seg == 2 && i == 77);
                step();
            end
            Reset = 1'b0;
        end

        // Reset in the middle of a ramp with samples still buffered.
        for (int i = 0; i < 4; i++) pushOne(16'($urandom));
        waitNextTick();
        repeat (5) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkOutput("midreset_dac", dac_data, 16'h8000);
        checkOutput("midreset_ready", {15'd0, s_ready}, 16'd1);
        midErrors = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            step();
            if (dac_data !== 16'h8000) midErrors++;
        end
        checkOutput("midreset_no_stale", 16'(midErrors), 16'd0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
